uart_tx: RTL
============

# uart_tx

Serial transmitter stage that drains the transmit FIFO and shifts each byte onto the UART line as start bit, LSB-first data, optional parity and stop period. It sits directly downstream of the TX FIFO: it watches the FIFO `empty` flag, pulses the FIFO `rd` input, and captures the FIFO's registered read data. Bit timing comes from an external oversampling baud tick (`s_tick`) shared with the receiver.

## Interface
- `data_bit`, 8: data bits per frame.
- `os_tick`, 16: `s_tick` pulses per data, start or parity bit.
- `sb_tick`, 16: `s_tick` pulses in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `parity_en`, 0: 1 inserts a parity bit after the data bits.
- `parity_odd`, 0: 1 selects odd parity, 0 selects even. Ignored when `parity_en` = 0.

- `clk` input 1: single clock. All logic is clocked on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `s_tick` input 1: one-`clk` baud-oversample strobe.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_r_data` input `data_bit`: FIFO read data. Valid on the cycle after `fifo_rd` is sampled high.
- `fifo_rd` output 1: one-cycle pop strobe to the FIFO.
- `tx` output 1: serial line. Idle level is high.
- `tx_busy` output 1: high in every state except IDLE.
- `tx_done_tick` output 1: one-cycle pulse when a frame's stop period completes.

## Operation
- Registers:
  - state
  - tick counter `s` (4+ bits, sized to count to max(`os_tick`, `sb_tick`)−1)
  - bit counter `n` (`clog2(data_bit)` bits)
  - shift register `b` (`data_bit` bits)
  - parity bit `p`
  - `tx_reg`
- States:
  - **IDLE**:
    - Drive `tx_reg`=1.
    - If `fifo_empty`=0: `fifo_rd`=1 (combinational, this cycle only), go to FETCH.
  - **FETCH** (exactly one cycle):
    - Load `b` ← `fifo_r_data`.
    - Load `p` ← XOR-reduce(`fifo_r_data`) XOR `parity_odd`.
    - `s` ← 0, go to START.
  - **START**:
    - `tx_reg`=0.
    - On each `s_tick`: if `s`=`os_tick`−1, set `s` ← 0, `n` ← 0 and go to DATA; otherwise `s`++.
  - **DATA**:
    - `tx_reg`=`b[0]`.
    - On `s_tick` with `s`=`os_tick`−1: set `s` ← 0 and `b` ← `b`>>1.
    - If `n`=`data_bit`−1, go to PARITY when `parity_en`=1, else to STOP. Otherwise `n`++.
  - **PARITY**: `tx_reg`=`p`. After `os_tick` ticks, go to STOP.
  - **STOP**:
    - `tx_reg`=1.
    - On `s_tick` with `s`=`sb_tick`−1: pulse `tx_done_tick` and go to IDLE.
- `fifo_rd` is never asserted while `fifo_empty`=1, and never more than once per frame.
- A `s_tick` arriving during IDLE or FETCH is ignored. Counting starts in START.
- Back-to-back frames: after STOP, IDLE samples `fifo_empty` on the next cycle. There are no extra idle bits beyond the stop period.

## Timing
- Reset values:
  - `tx`=1, `fifo_rd`=0, `tx_busy`=0, `tx_done_tick`=0.
  - State IDLE, all counters 0.
- `tx` is registered: it changes one `clk` after the state/bit transition that causes it. This guarantees a glitch-free line.
- Latency from `fifo_empty` falling (IDLE) to `tx` falling: 3 `clk` cycles (IDLE → FETCH → START → `tx_reg` update).
- Frame length is exactly (1 + `data_bit` + `parity_en`)·`os_tick` + `sb_tick` `s_tick` pulses, measured from the first tick in START.
- `tx_done_tick` is high for exactly one cycle, coincident with the STOP→IDLE transition.
- If `fifo_empty` falls in the same cycle `tx_done_tick` fires, `fifo_rd` asserts on the following cycle.
- Reset asserted mid-frame:
  - `tx` goes high immediately (asynchronous).
  - The in-flight byte is discarded; it was already popped and is not re-read.
  - No `tx_done_tick` is produced.
- `s_tick` high for consecutive cycles counts once per cycle. The block does not edge-detect.

## Test plan
1. **Reset and idle.** Assert `reset` with `fifo_empty`=1, then release and run 200 cycles with `s_tick` every 4 `clk` → `tx`=1, `fifo_rd`=0, `tx_busy`=0 throughout.
2. **Single byte.** FIFO holds 0xA5, defaults, `s_tick` every 4 `clk` → exactly one `fifo_rd` pulse. Line is 0, 1,0,1,0,0,1,0,1, 1; each bit lasts 64 `clk`, stop lasts 64 `clk`. One `tx_done_tick`, then `tx_busy`=0.
3. **Parity.** `parity_en`=1, `parity_odd`=0, byte 0x07 → parity bit 1. Repeat with `parity_odd`=1 → parity bit 0. Frame is 11 bit periods.
4. **Back-to-back.** FIFO preloaded with 0x00, 0xFF, 0x3C → three `fifo_rd` pulses, three frames with no gap beyond the stop period, three `tx_done_tick` pulses. Data matches in order.
5. **Reset mid-frame.** Pulse `reset` during data bit 4 of 0x81 → `tx`=1 in the same cycle, state IDLE, no `tx_done_tick`. With FIFO empty afterward, no further activity.
6. **Stop length.** `sb_tick`=32 → stop period is 32 ticks (128 `clk`). The next start bit is not earlier than that.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: drains the TX FIFO and serialises each byte as start bit, LSB-first data,
// optional parity and a stop period, timed by an external oversampling tick.
module uart_tx #(
   parameter int data_bit = 8,
   parameter int os_tick = 16,
   parameter int sb_tick = 16,
   parameter bit parity_en = 1'b0,
   parameter bit parity_odd = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_tick,
   input  logic                fifo_empty,
   input  logic [data_bit-1:0] fifo_r_data,
   output logic                fifo_rd,
   output logic                tx,
   output logic                tx_busy,
   output logic                tx_done_tick
);
   localparam int max_tick = os_tick > sb_tick ? os_tick : sb_tick;
   localparam int sw = $clog2(max_tick) > 4 ? $clog2(max_tick) : 4;
   localparam int nw = data_bit > 1 ? $clog2(data_bit) : 1;
   localparam logic [sw-1:0] os_last = sw'(os_tick - 1);
   localparam logic [sw-1:0] sb_last = sw'(sb_tick - 1);
   localparam logic [nw-1:0] n_last = nw'(data_bit - 1);
   typedef enum logic [2:0] {st_idle, st_fetch, st_start, st_data, st_parity, st_stop} state_t;
   state_t state;
   logic [sw-1:0] s;
   logic [nw-1:0] n;
   logic [data_bit-1:0] b;
   logic p;
   logic tx_reg;
   logic os_end;
   assign os_end = s_tick && s == os_last;
   assign fifo_rd = state == st_idle && !fifo_empty;
   assign tx_busy = state != st_idle;
   assign tx_done_tick = state == st_stop && s_tick && s == sb_last;
   assign tx = tx_reg;
   // The line level follows the current state one clock later, so tx never glitches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= st_idle;
         s <= '0;
         n <= '0;
         b <= '0;
         p <= 1'b0;
         tx_reg <= 1'b1;
      end else begin
         tx_reg <= state == st_start ? 1'b0 : state == st_data ? b[0] : state == st_parity ? p : 1'b1;
         case (state)
            st_idle: if (!fifo_empty) state <= st_fetch;
            st_fetch: begin
               b <= fifo_r_data;
               p <= ^fifo_r_data ^ parity_odd;
               s <= '0;
               state <= st_start;
            end
            st_start: if (s_tick) begin
               s <= os_end ? '0 : s + 1'b1;
               if (os_end) begin
                  n <= '0;
                  state <= st_data;
               end
            end
            st_data: if (s_tick) begin
               s <= os_end ? '0 : s + 1'b1;
               if (os_end) begin
                  b <= b >> 1;
                  n <= n + 1'b1;
                  if (n == n_last) state <= parity_en ? st_parity : st_stop;
               end
            end
            st_parity: if (s_tick) begin
               s <= os_end ? '0 : s + 1'b1;
               if (os_end) state <= st_stop;
            end
            st_stop: if (s_tick) begin
               s <= s == sb_last ? '0 : s + 1'b1;
               if (s == sb_last) state <= st_idle;
            end
            default: state <= st_idle;
         endcase
      end
   end
endmodule
